fft_input_framer: RTL and testbench

Upstream feeder for the 8-point radix-2 pipelined FFT datapath. Accepts a serial stream of W-bit samples, one per clock, with a valid/ready handshake. Assembles each group of 8 samples into a frame in a ping-pong (two-bank) buffer and presents the frame as eight parallel words in the order the first butterfly stage consumes. The output is bit-reversed by default or natural order by parameter. Frames are released downstream with a valid/ready handshake, which makes the block the boundary between the serial sample source and the parallel FFT pipeline.

---
 rtl/fft_input_framer.sv | 118 +++++++++++
 tb/tb_fft_input_framer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_framer.sv
// fft_input_framer: collects serial W-bit samples into 8-sample frames held in
// a two-bank ping-pong buffer. Each frame is presented as eight parallel words
// in bit-reversed order (BITREV=1) or natural order (BITREV=0).
module fft_input_framer #(
   parameter int unsigned W      = 8,
   parameter bit          BITREV = 1'b1
) (
   input  logic         clk_1,
   input  logic         rst_n,
   input  logic [W-1:0] s_data,
   input  logic         s_valid,
   input  logic         s_sof,
   output logic         s_ready,
   output logic [W-1:0] out1,
   output logic [W-1:0] out2,
   output logic [W-1:0] out3,
   output logic [W-1:0] out4,
   output logic [W-1:0] out5,
   output logic [W-1:0] out6,
   output logic [W-1:0] out7,
   output logic [W-1:0] out8,
   output logic         f_valid,
   input  logic         f_ready,
   output logic         err_sync
);

   localparam int unsigned N  = 8;
   localparam int unsigned IW = 3;

   logic [W-1:0]  bank [2][N];
   logic [1:0]    full, full_nxt;
   logic          wr_bank, wr_bank_nxt;
   logic          rd_bank, rd_bank_nxt;
   logic [IW-1:0] wr_cnt, wr_cnt_nxt;
   logic [IW-1:0] idx;
   logic          accept, consume, err_nxt;
   logic [W-1:0]  word [N];

   // Mirror a 3-bit index: the order the first butterfly stage consumes.
   function automatic logic [IW-1:0] rev3(input logic [IW-1:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   assign s_ready = !full[wr_bank];
   assign f_valid = full[rd_bank];
   assign accept  = s_valid && s_ready;
   assign consume = f_valid && f_ready;

   // Next-state for bank flags, pointers and write index; a fill and a
   // consume on the same edge always hit different banks.
   always_comb begin
      full_nxt    = full;
      wr_bank_nxt = wr_bank;
      rd_bank_nxt = rd_bank;
      wr_cnt_nxt  = wr_cnt;
      err_nxt     = 1'b0;
      idx         = s_sof ? IW'(0) : wr_cnt;
      if (accept) begin
         wr_cnt_nxt = idx + IW'(1);
         err_nxt    = s_sof && (wr_cnt != IW'(0));
         if (idx == IW'(N - 1)) begin
            full_nxt[wr_bank] = 1'b1;
            wr_bank_nxt       = !wr_bank;
         end
      end
      if (consume) begin
         full_nxt[rd_bank] = 1'b0;
         rd_bank_nxt       = !rd_bank;
      end
   end

   // Control state registers.
   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         full     <= 2'b00;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_cnt   <= IW'(0);
         err_sync <= 1'b0;
      end else begin
         full     <= full_nxt;
         wr_bank  <= wr_bank_nxt;
         rd_bank  <= rd_bank_nxt;
         wr_cnt   <= wr_cnt_nxt;
         err_sync <= err_nxt;
      end
   end

   // Sample storage; a resync simply restarts writing at index 0.
   always_ff @(posedge clk_1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned i = 0; i < N; i++) begin
               bank[b][i] <= '0;
            end
         end
      end else if (accept) begin
         bank[wr_bank][idx] <= s_data;
      end
   end

   // Parallel readout of the read bank in the selected order.
   always_comb begin
      for (int unsigned k = 0; k < N; k++) begin
         word[k] = bank[rd_bank][BITREV ? rev3(IW'(k)) : IW'(k)];
      end
   end

   assign out1 = word[0];
   assign out2 = word[1];
   assign out3 = word[2];
   assign out4 = word[3];
   assign out5 = word[4];
   assign out6 = word[5];
   assign out7 = word[6];
   assign out8 = word[7];

endmodule

// File: tb/tb_fft_input_framer.sv
// Bench for fft_input_framer: two instances (bit-reversed and natural order)
// share one stimulus stream and are compared against a frame-queue model.
module tb_fft_input_framer;

   logic       clk_1 = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_sof = 1'b0;
   logic       f_ready = 1'b0;

   logic       sr_r, fv_r, err_r;
   logic       sr_n, fv_n, err_n;
   logic [7:0] out_r [8];
   logic [7:0] out_n [8];

   always #5 clk_1 = ~clk_1;

   fft_input_framer #(.W(8), .BITREV(1'b1)) u_rev (
      .clk_1(clk_1), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
      .s_sof(s_sof), .s_ready(sr_r),
      .out1(out_r[0]), .out2(out_r[1]), .out3(out_r[2]), .out4(out_r[3]),
      .out5(out_r[4]), .out6(out_r[5]), .out7(out_r[6]), .out8(out_r[7]),
      .f_valid(fv_r), .f_ready(f_ready), .err_sync(err_r)
   );

   fft_input_framer #(.W(8), .BITREV(1'b0)) u_nat (
      .clk_1(clk_1), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
      .s_sof(s_sof), .s_ready(sr_n),
      .out1(out_n[0]), .out2(out_n[1]), .out3(out_n[2]), .out4(out_n[3]),
      .out5(out_n[4]), .out6(out_n[5]), .out7(out_n[6]), .out8(out_n[7]),
      .f_valid(fv_n), .f_ready(f_ready), .err_sync(err_n)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: completed frames waiting downstream plus the partial frame.
   typedef logic [7:0][7:0] frame_t;
   frame_t     fq [$];
   logic [7:0] part [$];
   bit         m_err;
   bit         last_acc;

   function automatic int rev(input int k);
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
   endfunction

   task automatic model_reset();
      fq.delete();
      part.delete();
      m_err    = 1'b0;
      last_acc = 1'b0;
   endtask

   task automatic check_all();
      chk("s_ready_rev", sr_r, fq.size() < 2);
      chk("s_ready_nat", sr_n, fq.size() < 2);
      chk("f_valid_rev", fv_r, fq.size() > 0);
      chk("f_valid_nat", fv_n, fq.size() > 0);
      chk("err_sync_rev", err_r, m_err);
      chk("err_sync_nat", err_n, m_err);
      if (fq.size() > 0) begin
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("out%0d_rev", k + 1), out_r[k], fq[0][rev(k)]);
            chk($sformatf("out%0d_nat", k + 1), out_n[k], fq[0][k]);
         end
      end
   endtask

   // Drive one cycle, advance the model across the edge, then check.
   task automatic step(input bit v, input bit sof, input logic [7:0] d, input bit fr);
      bit     acc, con;
      frame_t f;
      s_valid = v;
      s_sof   = sof;
      s_data  = d;
      f_ready = fr;
      acc = v && (fq.size() < 2);
      con = (fq.size() > 0) && fr;
      @(posedge clk_1);
      m_err = 1'b0;
      if (con) f = fq.pop_front();
      if (acc) begin
         if (sof) begin
            m_err = (part.size() != 0);
            part.delete();
         end
         part.push_back(d);
         if (part.size() == 8) begin
            for (int i = 0; i < 8; i++) f[i] = part[i];
            fq.push_back(f);
            part.delete();
         end
      end
      last_acc = acc;
      #1;
      check_all();
   endtask

   typedef struct {
      bit         v;
      bit         sof;
      logic [7:0] d;
      bit         fr;
      bit         e_ready;
      bit         e_fvalid;
      bit         e_err;
   } vec_t;

   vec_t       tbl [9];
   logic [7:0] exp_rev [8];

   initial begin
      int i;
      int drops;
      int fvc;

      for (int k = 0; k < 8; k++) begin
         tbl[k].v        = 1'b1;
         tbl[k].sof      = (k == 0);
         tbl[k].d        = 8'(8'h10 + k);
         tbl[k].fr       = 1'b1;
         tbl[k].e_ready  = 1'b1;
         tbl[k].e_fvalid = (k == 7);
         tbl[k].e_err    = 1'b0;
      end
      tbl[8] = '{v: 1'b0, sof: 1'b0, d: 8'h00, fr: 1'b1, e_ready: 1'b1, e_fvalid: 1'b0, e_err: 1'b0};
      exp_rev = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};

      // Reset state
      model_reset();
      #12;
      chk("rst_s_ready", sr_r, 1);
      chk("rst_f_valid", fv_r, 0);
      chk("rst_err", err_r, 0);
      for (int k = 0; k < 8; k++) begin
         chk("rst_out_rev", out_r[k], 0);
         chk("rst_out_nat", out_n[k], 0);
      end
      @(negedge clk_1) rst_n = 1'b1;
      @(posedge clk_1);
      #1;

      // Single frame, both orders
      for (int t = 0; t < 9; t++) begin
         step(tbl[t].v, tbl[t].sof, tbl[t].d, tbl[t].fr);
         chk("tv_s_ready", sr_r, tbl[t].e_ready);
         chk("tv_f_valid", fv_r, tbl[t].e_fvalid);
         chk("tv_f_valid_nat", fv_n, tbl[t].e_fvalid);
         chk("tv_err", err_r, tbl[t].e_err);
         if (t == 7) begin
            for (int k = 0; k < 8; k++) begin
               chk("tv_out_rev", out_r[k], exp_rev[k]);
               chk("tv_out_nat", out_n[k], 8'(8'h10 + k));
            end
         end
      end

      // Backpressure: two frames fill, the 17th sample is held
      i = 0;
      for (int c = 0; c < 100 && i < 16; c++) begin
         step(1'b1, (i % 8) == 0, 8'(8'h40 + i), 1'b0);
         if (last_acc) i++;
      end
      chk("bp_accepts", i, 16);
      chk("bp_ready_low", sr_r, 0);
      repeat (3) begin
         step(1'b1, 1'b1, 8'h50, 1'b0);
         chk("bp_held", last_acc, 0);
      end
      step(1'b1, 1'b1, 8'h50, 1'b1);
      chk("bp_release_no_accept", last_acc, 0);
      chk("bp_ready_back", sr_r, 1);
      for (int c = 0; c < 100 && i < 24; c++) begin
         step(1'b1, (i % 8) == 0, 8'(8'h40 + i), 1'b0);
         if (last_acc) i++;
      end
      chk("bp_accepts_all", i, 24);
      repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("bp_drained", fv_r, 0);

      // Resync on a mid-frame start-of-frame
      step(1'b1, 1'b1, 8'h20, 1'b1);
      step(1'b1, 1'b0, 8'h21, 1'b1);
      step(1'b1, 1'b0, 8'h22, 1'b1);
      step(1'b1, 1'b1, 8'h30, 1'b1);
      chk("rs_err_pulse", err_r, 1);
      for (int k = 1; k < 8; k++) begin
         step(1'b1, 1'b0, 8'(8'h30 + k), 1'b1);
         chk("rs_err_single", err_r, 0);
      end
      chk("rs_f_valid", fv_r, 1);
      for (int k = 0; k < 8; k++) chk("rs_frame_nat", out_n[k], 8'(8'h30 + k));
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Back-to-back streaming
      drops = 0;
      fvc   = 0;
      for (int k = 0; k < 64; k++) begin
         step(1'b1, (k % 8) == 0, 8'(8'h80 + k), 1'b1);
         if (!last_acc || !sr_r) drops++;
         if (fv_r) fvc++;
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (fv_r) fvc++;
      chk("b2b_drops", drops, 0);
      chk("b2b_fvalid_cycles", fvc, 8);

      // Async reset in the middle of a frame
      for (int k = 0; k < 5; k++) step(1'b1, k == 0, 8'(8'hA0 + k), 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_s_ready", sr_r, 1);
      chk("ar_f_valid", fv_r, 0);
      chk("ar_err", err_r, 0);
      for (int k = 0; k < 8; k++) begin
         chk("ar_out_rev", out_r[k], 0);
         chk("ar_out_nat", out_n[k], 0);
      end
      model_reset();
      s_valid = 1'b0;
      @(negedge clk_1) rst_n = 1'b1;
      @(posedge clk_1);
      #1;
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'(8'h60 + k), 1'b0);
      chk("ar_refill_valid", fv_n, 1);
      for (int k = 0; k < 8; k++) chk("ar_refill_nat", out_n[k], 8'(8'h60 + k));
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              8'($urandom), $urandom_range(0, 2) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
